// File: rtl/raster_pkg.sv
// Shared types and defaults for the rasterizer front end.
//   coord_t      : signed screen/vertex coordinate
//   bbox_t       : axis-aligned bounding box {min_x, max_x, min_y, max_y}
//   iter_state_t : pixel iterator FSM states
// Also holds signed min/max helpers used by the bounding-box logic.
package raster_pkg;

  localparam int COORD_W_DEF  = 16;
  localparam int SCREEN_W_DEF = 320;
  localparam int SCREEN_H_DEF = 240;

  typedef logic signed [COORD_W_DEF-1:0] coord_t;

  typedef struct packed {
    coord_t min_x;
    coord_t max_x;
    coord_t min_y;
    coord_t max_y;
  } bbox_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } iter_state_t;

  function automatic coord_t smin(input coord_t a, input coord_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic coord_t smax(input coord_t a, input coord_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bbox_clamp.sv
// Combinational bounding box of a triangle, intersected with the screen.
// Ports:
//   x0..y2 : signed vertex coordinates
//   box    : clamped box (min clamped up to 0, max clamped down to edge)
//   empty  : box does not intersect the screen
module bbox_clamp
  import raster_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  coord_t x0,
  input  coord_t y0,
  input  coord_t x1,
  input  coord_t y1,
  input  coord_t x2,
  input  coord_t y2,
  output bbox_t  box,
  output logic   empty
);

  localparam coord_t X_HI = coord_t'(SCREEN_W - 1);
  localparam coord_t Y_HI = coord_t'(SCREEN_H - 1);
  localparam coord_t ZERO = '0;

  coord_t lo_x, hi_x, lo_y, hi_y;

  // Only the lower bound is raised and the upper bound lowered, so a box
  // lying wholly off one side ends up with min > max and reads as empty.
  always_comb begin
    lo_x  = smax(smin(smin(x0, x1), x2), ZERO);
    hi_x  = smin(smax(smax(x0, x1), x2), X_HI);
    lo_y  = smax(smin(smin(y0, y1), y2), ZERO);
    hi_y  = smin(smax(smax(y0, y1), y2), Y_HI);
    empty = (lo_x > hi_x) || (lo_y > hi_y);
    box   = '{min_x: lo_x, max_x: hi_x, min_y: lo_y, max_y: hi_y};
  end

endmodule

// File: rtl/pixel_iterator.sv
// Rasterizer pixel stream producer. Accepts one triangle per handshake,
// holds its vertices on o_x*/o_y*, and walks the screen-clipped bounding
// box in raster order, one candidate pixel per cycle.
// Ports:
//   i_clk, i_rst_n         : clock, synchronous active-low reset
//   i_tri_valid/o_tri_ready: triangle handshake (ready only in IDLE)
//   i_x0..i_y2             : incoming vertices
//   o_x0..o_y2             : latched vertices, stable for the traversal
//   i_stall                : freezes traversal while in SCAN
//   o_p_x, o_p_y, o_valid  : current pixel and its qualifier
//   o_done                 : one-cycle end-of-triangle pulse
//   o_busy                 : any state other than IDLE
module pixel_iterator
  import raster_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int COORD_W  = COORD_W_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_tri_valid,
  output logic                      o_tri_ready,
  input  logic signed [COORD_W-1:0] i_x0,
  input  logic signed [COORD_W-1:0] i_y0,
  input  logic signed [COORD_W-1:0] i_x1,
  input  logic signed [COORD_W-1:0] i_y1,
  input  logic signed [COORD_W-1:0] i_x2,
  input  logic signed [COORD_W-1:0] i_y2,
  output logic signed [COORD_W-1:0] o_x0,
  output logic signed [COORD_W-1:0] o_y0,
  output logic signed [COORD_W-1:0] o_x1,
  output logic signed [COORD_W-1:0] o_y1,
  output logic signed [COORD_W-1:0] o_x2,
  output logic signed [COORD_W-1:0] o_y2,
  input  logic                      i_stall,
  output logic signed [COORD_W-1:0] o_p_x,
  output logic signed [COORD_W-1:0] o_p_y,
  output logic                      o_valid,
  output logic                      o_done,
  output logic                      o_busy
);

  iter_state_t state;
  bbox_t       box;
  logic        box_empty;

  // Box limits needed while scanning; min_y is only used once at SETUP.
  logic signed [COORD_W-1:0] min_x_p1, max_x_p1, max_y_p1;

  assign o_tri_ready = (state == IDLE);

  // Fed from the latched vertices, so the result is settled during SETUP.
  bbox_clamp #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_bbox (
    .x0    (o_x0),
    .y0    (o_y0),
    .x1    (o_x1),
    .y1    (o_y1),
    .x2    (o_x2),
    .y2    (o_y2),
    .box   (box),
    .empty (box_empty)
  );

  // SETUP -> SCAN boundary: capture the traversal limits.
  always_ff @(posedge i_clk) begin
    if (state == SETUP) begin
      min_x_p1 <= box.min_x;
      max_x_p1 <= box.max_x;
      max_y_p1 <= box.max_y;
    end
  end

  // The pixel outputs double as the traversal counters; they are loaded
  // only on entry to SCAN so they hold their last value outside it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      o_valid <= 1'b0;
      o_done  <= 1'b0;
      o_busy  <= 1'b0;
      o_p_x   <= '0;
      o_p_y   <= '0;
      o_x0    <= '0;
      o_y0    <= '0;
      o_x1    <= '0;
      o_y1    <= '0;
      o_x2    <= '0;
      o_y2    <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_tri_valid) begin
            o_x0   <= i_x0;
            o_y0   <= i_y0;
            o_x1   <= i_x1;
            o_y1   <= i_y1;
            o_x2   <= i_x2;
            o_y2   <= i_y2;
            o_busy <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          if (box_empty) begin
            o_done <= 1'b1;
            state  <= DONE;
          end else begin
            o_p_x   <= box.min_x;
            o_p_y   <= box.min_y;
            o_valid <= 1'b1;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (!i_stall) begin
            if (o_p_x == max_x_p1 && o_p_y == max_y_p1) begin
              o_valid <= 1'b0;
              o_done  <= 1'b1;
              state   <= DONE;
            end else if (o_p_x == max_x_p1) begin
              o_p_x <= min_x_p1;
              o_p_y <= o_p_y + 1'b1;
            end else begin
              o_p_x <= o_p_x + 1'b1;
            end
          end
        end
        DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_iterator.sv
module tb_pixel_iterator;

  localparam int SW = 320;
  localparam int SH = 240;

  logic               i_clk = 1'b0;
  logic               i_rst_n;
  logic               i_tri_valid;
  logic               o_tri_ready;
  logic signed [15:0] i_x0, i_y0, i_x1, i_y1, i_x2, i_y2;
  logic signed [15:0] o_x0, o_y0, o_x1, o_y1, o_x2, o_y2;
  logic               i_stall;
  logic signed [15:0] o_p_x, o_p_y;
  logic               o_valid, o_done, o_busy;

  int nvec = 0;
  int nerr = 0;
  int ev[6];
  int last_px = 0;
  int last_py = 0;

  always #5 i_clk = ~i_clk;

  pixel_iterator dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_tri_valid (i_tri_valid),
    .o_tri_ready (o_tri_ready),
    .i_x0        (i_x0),
    .i_y0        (i_y0),
    .i_x1        (i_x1),
    .i_y1        (i_y1),
    .i_x2        (i_x2),
    .i_y2        (i_y2),
    .o_x0        (o_x0),
    .o_y0        (o_y0),
    .o_x1        (o_x1),
    .o_y1        (o_y1),
    .o_x2        (o_x2),
    .o_y2        (o_y2),
    .i_stall     (i_stall),
    .o_p_x       (o_p_x),
    .o_p_y       (o_p_y),
    .o_valid     (o_valid),
    .o_done      (o_done),
    .o_busy      (o_busy)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_vtx();
    chk("o_x0", int'(o_x0), ev[0]);
    chk("o_y0", int'(o_y0), ev[1]);
    chk("o_x1", int'(o_x1), ev[2]);
    chk("o_y1", int'(o_y1), ev[3]);
    chk("o_x2", int'(o_x2), ev[4]);
    chk("o_y2", int'(o_y2), ev[5]);
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Junk on the triangle inputs while busy; must never be taken.
  task automatic scramble();
    i_tri_valid = 1'($urandom_range(0, 1));
    i_x0 = 16'($urandom_range(0, 900));
    i_y0 = 16'($urandom_range(0, 900));
    i_x1 = 16'($urandom_range(0, 900));
    i_y1 = 16'($urandom_range(0, 900));
    i_x2 = 16'($urandom_range(0, 900));
    i_y2 = 16'($urandom_range(0, 900));
  endtask

  // mode 0: no stall, 1: random stall, 2: stall 3 cycles on pixel index 1
  task automatic run_tri(input int ax0, input int ay0, input int ax1,
                         input int ay1, input int ax2, input int ay2,
                         input int mode);
    int qx[$];
    int qy[$];
    int lx, hx, ly, hy, idx, held, budget;
    bit st;
    lx = imax(imin(imin(ax0, ax1), ax2), 0);
    hx = imin(imax(imax(ax0, ax1), ax2), SW - 1);
    ly = imax(imin(imin(ay0, ay1), ay2), 0);
    hy = imin(imax(imax(ay0, ay1), ay2), SH - 1);
    for (int y = ly; y <= hy; y++)
      for (int x = lx; x <= hx; x++) begin
        qx.push_back(x);
        qy.push_back(y);
      end

    chk("ready_idle", int'(o_tri_ready), 1);
    i_x0 = 16'(ax0); i_y0 = 16'(ay0);
    i_x1 = 16'(ax1); i_y1 = 16'(ay1);
    i_x2 = 16'(ax2); i_y2 = 16'(ay2);
    i_tri_valid = 1'b1;
    i_stall = 1'($urandom_range(0, 1));
    @(posedge i_clk);
    #1;
    ev = '{ax0, ay0, ax1, ay1, ax2, ay2};
    scramble();

    @(negedge i_clk);
    chk("setup_valid", int'(o_valid), 0);
    chk("setup_done", int'(o_done), 0);
    chk("setup_busy", int'(o_busy), 1);
    chk("setup_ready", int'(o_tri_ready), 0);
    chk_vtx();
    i_stall = 1'($urandom_range(0, 1));
    scramble();

    idx = 0; held = 0; budget = 0;
    while (idx < qx.size()) begin
      @(negedge i_clk);
      budget++;
      if (budget > 4 * qx.size() + 16) begin
        chk("scan_timeout", budget, 0);
        break;
      end
      chk("scan_valid", int'(o_valid), 1);
      chk("scan_px", int'(o_p_x), qx[idx]);
      chk("scan_py", int'(o_p_y), qy[idx]);
      chk("scan_done", int'(o_done), 0);
      chk("scan_ready", int'(o_tri_ready), 0);
      chk_vtx();
      case (mode)
        1: st = ($urandom_range(0, 3) == 0);
        2: begin
          st = (idx == 1 && held < 3);
          if (st) held++;
        end
        default: st = 1'b0;
      endcase
      i_stall = st;
      scramble();
      if (!st) idx++;
    end

    if (qx.size() > 0) begin
      last_px = qx[qx.size() - 1];
      last_py = qy[qy.size() - 1];
    end
    @(negedge i_clk);
    chk("done_pulse", int'(o_done), 1);
    chk("done_valid", int'(o_valid), 0);
    chk("done_busy", int'(o_busy), 1);
    chk("done_ready", int'(o_tri_ready), 0);
    chk("done_px_hold", int'(o_p_x), last_px);
    chk("done_py_hold", int'(o_p_y), last_py);
    chk_vtx();
    i_stall = 1'($urandom_range(0, 1));
    scramble();

    @(negedge i_clk);
    chk("idle_done", int'(o_done), 0);
    chk("idle_busy", int'(o_busy), 0);
    chk("idle_valid", int'(o_valid), 0);
    chk("idle_ready", int'(o_tri_ready), 1);
    i_tri_valid = 1'b0;
    i_stall = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cx, cy;
    i_rst_n = 1'b0;
    i_tri_valid = 1'b0;
    i_stall = 1'b0;
    i_x0 = '0; i_y0 = '0; i_x1 = '0; i_y1 = '0; i_x2 = '0; i_y2 = '0;
    repeat (2) @(negedge i_clk);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_ready", int'(o_tri_ready), 1);
    chk("rst_px", int'(o_p_x), 0);
    chk("rst_py", int'(o_p_y), 0);
    ev = '{0, 0, 0, 0, 0, 0};
    chk_vtx();
    i_rst_n = 1'b1;
    @(negedge i_clk);

    run_tri(10, 10, 12, 10, 10, 11, 0);     // basic box
    run_tri(-5, -5, 4, 0, 0, 400, 0);       // clamped, 1200 pixels
    run_tri(400, 10, 500, 10, 450, 50, 0);  // off-screen, empty
    run_tri(10, 10, 12, 10, 10, 11, 2);     // directed stall on (11,10)
    run_tri(7, 7, 7, 7, 7, 7, 0);           // single point
    run_tri(319, 239, 330, 250, 318, 238, 1); // bottom-right corner

    // Reset in the middle of a traversal.
    i_x0 = 16'(10); i_y0 = 16'(10);
    i_x1 = 16'(12); i_y1 = 16'(10);
    i_x2 = 16'(10); i_y2 = 16'(11);
    i_tri_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_tri_valid = 1'b0;
    @(negedge i_clk);                        // SETUP
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      chk("pre_rst_px", int'(o_p_x), 10 + k);
      chk("pre_rst_py", int'(o_p_y), 10);
    end
    i_rst_n = 1'b0;
    @(negedge i_clk);
    chk("mid_rst_valid", int'(o_valid), 0);
    chk("mid_rst_busy", int'(o_busy), 0);
    chk("mid_rst_px", int'(o_p_x), 0);
    chk("mid_rst_py", int'(o_p_y), 0);
    chk("mid_rst_ready", int'(o_tri_ready), 1);
    chk("mid_rst_done", int'(o_done), 0);
    i_rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      chk("post_rst_done", int'(o_done), 0);
      chk("post_rst_valid", int'(o_valid), 0);
    end
    last_px = 0;
    last_py = 0;

    // Random small triangles scattered around and beyond the screen.
    for (int t = 0; t < 20; t++) begin
      cx = int'($urandom_range(0, 400)) - 40;
      cy = int'($urandom_range(0, 320)) - 40;
      run_tri(cx + int'($urandom_range(0, 12)) - 6, cy + int'($urandom_range(0, 12)) - 6,
              cx + int'($urandom_range(0, 12)) - 6, cy + int'($urandom_range(0, 12)) - 6,
              cx + int'($urandom_range(0, 12)) - 6, cy + int'($urandom_range(0, 12)) - 6,
              int'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pixel_iterator.md
Name: pixel_iterator

Overview:
- Producer side of the rasterizer pixel stream.
- Accepts one triangle per handshake, latches its vertices, and computes the screen-clipped bounding box.
- Walks the box in raster order, emitting one candidate pixel per cycle to the edge engine.
- Holds the latched vertices stable on its outputs for the whole traversal; these drive the edge engine's static triangle inputs.

Parameters:
- SCREEN_W, 320, screen width in pixels; valid x range is 0..SCREEN_W-1.
- SCREEN_H, 240, screen height in pixels; valid y range is 0..SCREEN_H-1.
- COORD_W, 16, signed coordinate width for vertices and pixel outputs.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_tri_valid  in  1  triangle vertices on i_x*/i_y* are valid.
- o_tri_ready  out  1  iterator can accept a triangle.
- i_x0, i_y0, i_x1, i_y1, i_x2, i_y2  in  COORD_W each  signed vertex coordinates.
- o_x0, o_y0, o_x1, o_y1, o_x2, o_y2  out  COORD_W each  latched vertices, stable during traversal.
- i_stall  in  1  downstream backpressure; freezes traversal.
- o_p_x, o_p_y  out  COORD_W each  signed pixel coordinate.
- o_valid  out  1  o_p_x/o_p_y carry a real pixel.
- o_done  out  1  one-cycle pulse at the end of a triangle.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (i_rst_n=0 at a rising edge):
  - state=IDLE.
  - o_valid, o_done, o_busy = 0.
  - o_p_x, o_p_y, o_x*, o_y* = 0.
  - Reset mid-traversal abandons the triangle; no o_done pulse.
- o_tri_ready = (state==IDLE), combinational, so it reads 1 while in reset. Accept = i_tri_valid && o_tri_ready.
- FSM states: IDLE, SETUP, SCAN, DONE.
  - IDLE -> SETUP on accept. Vertices are latched into o_x*/o_y* at the accept edge.
  - SETUP, one cycle, regardless of i_stall:
    - bbox min/max over the three vertices, per axis.
    - clamp x to [0, SCREEN_W-1] and y to [0, SCREEN_H-1].
    - load cur_x=min_x, cur_y=min_y.
    - if clamped min_x>max_x or min_y>max_y (box fully off-screen): -> DONE; else -> SCAN.
  - SCAN:
    - o_valid=1 and o_p_x/o_p_y=(cur_x, cur_y) whenever in SCAN.
    - If i_stall=1: cur, outputs and o_valid hold.
    - Else if cur==(max_x, max_y): -> DONE.
    - Else if cur_x==max_x: cur_x=min_x, cur_y+1.
    - Else: cur_x+1.
  - DONE: o_done=1, o_valid=0, -> IDLE. One cycle only.
- Latency, with accept at edge T:
  - SETUP during cycle T+1.
  - First pixel valid in cycle T+2.
  - With no stalls, last pixel valid at cycle T+1+N, where N = box area.
  - o_done in cycle T+2+N; o_tri_ready high again in cycle T+3+N.
  - Empty box: o_done in cycle T+2, ready in cycle T+3, zero valid pixels.
- o_valid=0 in IDLE, SETUP and DONE.
- o_p_x/o_p_y keep their last value when not valid.
- i_tri_valid is ignored unless in IDLE. No new triangle is accepted in the same cycle as o_done.
- Arithmetic:
  - bbox and clamp use signed COORD_W compares.
  - cur_x/cur_y counters are COORD_W wide and never exceed the clamped max, so there is no overflow.
- Degenerate triangles (collinear vertices or a single point) are still scanned over their box. Rejection is the edge engine's job.

Decomposition:
- Package raster_pkg:
  - coord_t (signed COORD_W logic).
  - bbox_t struct {min_x, max_x, min_y, max_y}.
  - iter_state_t enum {IDLE, SETUP, SCAN, DONE}.
  - SCREEN_W/SCREEN_H default constants.
- One combinational sub-module, bbox_clamp: three vertices in, clamped bbox_t plus empty flag out. It is instantiated in SETUP and unit-testable alone.

Test Plan:
- Basic box: vertices (10,10),(12,10),(10,11), accept at edge 0 -> pixels (10,10),(11,10),(12,10),(10,11),(11,11),(12,11) on cycles 2..7; o_done cycle 8; o_tri_ready cycle 9.
- Clamp: vertices (-5,-5),(4,0),(0,400) -> x 0..4, y 0..239; exactly 1200 valid pixels; first (0,0), last (4,239).
- Off-screen: vertices (400,10),(500,10),(450,50) -> zero o_valid cycles; o_done at cycle 2; o_x0 reads 400 throughout.
- Stall: on the basic box, hold i_stall=1 for 3 cycles while (11,10) is shown -> (11,10) held 4 cycles total; sequence otherwise unchanged; o_done delayed by 3.
- Single point: all vertices (7,7) -> one pixel (7,7) at cycle 2; o_done at cycle 3. Back-to-back i_tri_valid is accepted only when o_tri_ready=1 at cycle 4.
- Reset mid-scan: deassert i_rst_n after the 3rd pixel of the basic box -> next cycle o_valid=0, o_busy=0, o_p_x=0, o_p_y=0, o_tri_ready=1, and no o_done.
